mod_n_event_fsm: RTL and testbench

Parametrised modulo-N input-event counter FSM with a selectable Mealy or Moore detect output, enable/clear control and a saturating wrap counter. It is the generalised successor of the fixed 4-state pulse-counting machines in the sequential-logic exercise set. It counts high samples of `x_in` through states 1..N and wraps N→1. It sits between an input sampler and any logic that needs an "N-th event" strobe.

---
 rtl/mod_n_event_fsm.sv | 51 +++++
 tb/tb_mod_n_event_fsm.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mod_n_event_fsm.sv
// mod_n_event_fsm: modulo-N event counter with Mealy/Moore N-th-event detect and saturating wrap counter
module mod_n_event_fsm #(
  parameter int N     = 3,
  parameter bit MEALY = 1,
  localparam int SW   = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          x_in,
  output logic          y_out,
  output logic [SW-1:0] state,
  output logic          wrap,
  output logic [7:0]    wrap_cnt
);
  localparam logic [SW-1:0] NS = SW'(N);
  logic [SW-1:0] state_q, state_d;
  logic          wrap_q, wrap_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          legal, at_n, wrap_ev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end
  // Illegal encodings recover to idle even while disabled.
  always_comb begin
    legal   = state_q <= NS;
    at_n    = state_q == NS;
    wrap_ev = en && !clr && x_in && at_n;
    state_d = (clr || !legal) ? '0
            : (!en || !x_in)  ? state_q
            : at_n            ? SW'(1)
            :                   state_q + 1'b1;
    wrap_d  = !clr && wrap_ev;
    cnt_d   = clr                        ? 8'd0
            : (wrap_ev && cnt_q != 8'hff) ? cnt_q + 8'd1
            :                               cnt_q;
    y_out   = MEALY ? (state_d == NS) : at_n;
  end
  assign state    = state_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = cnt_q;
endmodule

// File: tb/tb_mod_n_event_fsm.sv
// tb_mod_n_event_fsm: directed checks of the modulo-N event counter in Mealy and Moore builds
module tb_mod_n_event_fsm;
  logic clk = 1'b0, rst = 1'b0, en = 1'b1, clr = 1'b0, x = 1'b0;
  logic       y3a, y3m, y5m, y5a, w3a, w3m, w5m, w5a;
  logic [1:0] s3a, s3m;
  logic [2:0] s5m, s5a;
  logic [7:0] c3a, c3m, c5m, c5a;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mod_n_event_fsm #(.N(3), .MEALY(1)) u3a (.clk(clk), .rst(rst), .en(en), .clr(clr), .x_in(x),
    .y_out(y3a), .state(s3a), .wrap(w3a), .wrap_cnt(c3a));
  mod_n_event_fsm #(.N(3), .MEALY(0)) u3m (.clk(clk), .rst(rst), .en(en), .clr(clr), .x_in(x),
    .y_out(y3m), .state(s3m), .wrap(w3m), .wrap_cnt(c3m));
  mod_n_event_fsm #(.N(5), .MEALY(0)) u5m (.clk(clk), .rst(rst), .en(en), .clr(clr), .x_in(x),
    .y_out(y5m), .state(s5m), .wrap(w5m), .wrap_cnt(c5m));
  mod_n_event_fsm #(.N(5), .MEALY(1)) u5a (.clk(clk), .rst(rst), .en(en), .clr(clr), .x_in(x),
    .y_out(y5a), .state(s5a), .wrap(w5a), .wrap_cnt(c5a));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e1 [7] = '{1, 2, 3, 1, 2, 3, 1};
    int w1 [7] = '{0, 0, 0, 1, 0, 0, 1};
    int st;
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 32'(s3a), 0); chk("rst_y_mealy", 32'(y3a), 0); chk("rst_y_moore", 32'(y3m), 0);
    chk("rst_wrap", 32'(w3a), 0);  chk("rst_cnt", 32'(c3a), 0);
    rst = 1'b0;
    x = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("cont_state", 32'(s3a), 32'(e1[i]));
      chk("cont_y_mealy", 32'(y3a), 32'(e1[i] == 2));
      chk("cont_y_moore", 32'(y3m), 32'(e1[i] == 3));
      chk("cont_wrap", 32'(w3a), 32'(w1[i]));
    end
    chk("cont_cnt", 32'(c3a), 2);
    step(); step();
    chk("pre_hold_state", 32'(s3a), 3);
    x = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_y_mealy", 32'(y3a), 1);
      chk("hold_y_moore", 32'(y3m), 1);
      step();
      chk("hold_state", 32'(s3a), 3);
    end
    x = 1'b1;
    #1;
    chk("leave_y_mealy", 32'(y3a), 0);
    chk("leave_y_moore", 32'(y3m), 1);
    step();
    chk("leave_state", 32'(s3a), 1);
    chk("leave_wrap", 32'(w3a), 1);
    chk("leave_cnt", 32'(c3m), 3);
    step();
    chk("en_pre_state", 32'(s3a), 2);
    en = 1'b0;
    #1;
    chk("en0_y_mealy", 32'(y3a), 0);
    step(); step();
    chk("en0_state", 32'(s3a), 2);
    chk("en0_wrap", 32'(w3a), 0);
    en = 1'b1; clr = 1'b1;
    #1;
    chk("clr_y_mealy", 32'(y3a), 0);
    step();
    chk("clr_state", 32'(s3a), 0);
    chk("clr_cnt", 32'(c3a), 0);
    chk("clr_y_after", 32'(y3a), 0);
    clr = 1'b0;
    step(); step();
    chk("arst_pre_state", 32'(s3a), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(s3a), 0); chk("arst_y_mealy", 32'(y3a), 0);
    chk("arst_wrap", 32'(w3a), 0);  chk("arst_cnt", 32'(c3m), 0);
    rst = 1'b0;
    step();
    chk("arst_first_edge", 32'(s3a), 1);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    for (int e = 1; e <= 1501; e++) begin
      step();
      st = ((e - 1) % 5) + 1;
      chk("sat_state", 32'(s5m), 32'(st));
      chk("sat_y_moore", 32'(y5m), 32'(st == 5));
      chk("sat_y_mealy", 32'(y5a), 32'(st == 4));
      chk("sat_wrap", 32'(w5m), 32'(e > 1 && (e - 1) % 5 == 0));
      chk("sat_cnt", 32'(c5m), 32'(((e - 1) / 5) > 255 ? 255 : (e - 1) / 5));
    end
    chk("sat_final_cnt", 32'(c5a), 255);
    @(negedge clk);
    force u5m.state_q = 3'd7;
    force u5a.state_q = 3'd7;
    #1;
    chk("ill_y_moore", 32'(y5m), 0);
    chk("ill_y_mealy", 32'(y5a), 0);
    release u5m.state_q;
    release u5a.state_q;
    step();
    chk("ill_state_moore", 32'(s5m), 0);
    chk("ill_state_mealy", 32'(s5a), 0);
    chk("ill_wrap", 32'(w5m), 0);
    chk("ill_cnt", 32'(c5m), 255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
